diag_readback_collector: RTL and testbench

DIAG_READBACK_COLLECTOR -- requirements
Module: diag_readback_collector

---
 rtl/diag_readback_collector_pkg.sv | 25 ++
 rtl/diag_readback_collector_ram.sv | 22 ++
 rtl/diag_readback_collector.sv | 129 ++++++++++++
 tb/tb_diag_readback_collector.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/diag_readback_collector_pkg.sv
// Shared types and helpers for the diagnostic read-back collector.
package DiagPkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_DONE    = 2'b10
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam int         TIMER_W   = 24;

    // One byte of CRC-8, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                             input logic [7:0] data_byte);
        logic [7:0] c;
        c = crc ^ data_byte;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/diag_readback_collector_ram.sv
// Byte store for read-back data: one sync write port, one sync read port.
// No reset; the collector masks any location that is not yet written.
module diag_readback_ram #(
    parameter int g_Depth = 16
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(g_Depth)-1:0] wr_addr,
    input  logic [7:0]                 wr_data,
    input  logic [$clog2(g_Depth)-1:0] rd_addr,
    output logic [7:0]                 rd_data
);

    logic [7:0] mem [g_Depth];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/diag_readback_collector.sv
// Collects bytes read back from an I2C slave during one session, keeps a
// running CRC-8 and offers the stored bytes to the host for readout.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | no session since reset; bytes and Finished_i ignored
//  ST_COLLECT | session open; every valid byte accepted, timer running
//  ST_DONE    | session closed (Finished_i or timeout); results held
//
// Start_i always (re)opens a session from any state and beats Finished_i.
// A full store keeps Ready_o high so the I2C path never stalls; excess
// bytes are dropped and flagged instead.
module diag_readback_collector
    import DiagPkg::*;
#(
    parameter int g_Depth         = 16,
    parameter int g_TimeoutCycles = 1000000
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       Start_i,
    input  logic                       Finished_i,
    input  logic [7:0]                 Data_i8b,
    input  logic                       Valid_i,
    output logic                       Ready_o,
    input  logic [$clog2(g_Depth)-1:0] RdAddr_i,
    output logic [7:0]                 RdData_o8b,
    output logic [$clog2(g_Depth):0]   Count_o,
    output logic [7:0]                 Crc_o8b,
    output logic                       Overflow_o,
    output logic                       Timeout_o,
    output logic                       Complete_o
);

    localparam int                  c_AddrW     = $clog2(g_Depth);
    localparam int                  c_CntW      = c_AddrW + 1;
    localparam logic [c_CntW-1:0]   c_Full      = c_CntW'(g_Depth);
    localparam logic [c_CntW-1:0]   c_CntOne    = c_CntW'(1);
    localparam logic [TIMER_W-1:0]  c_TimerLast = TIMER_W'(g_TimeoutCycles - 1);
    localparam logic [TIMER_W-1:0]  c_TimerOne  = TIMER_W'(1);

    state_t              state;
    logic [TIMER_W-1:0]  timer;
    logic [c_CntW-1:0]   count;
    logic [7:0]          crc;
    logic                overflow;
    logic                timeout;
    logic                rd_valid;
    logic [7:0]          ram_q;

    logic in_collect;
    logic accept;
    logic full;
    logic store;
    logic timeout_hit;

    assign in_collect  = (state == ST_COLLECT);
    assign accept      = in_collect && Valid_i;
    assign full        = (count == c_Full);
    // A byte arriving with Start_i belongs to the abandoned session.
    assign store       = accept && !full && !Start_i;
    // An accepted byte resets the idle timer, so it cannot time out.
    assign timeout_hit = in_collect && !accept && (timer == c_TimerLast);

    // Session FSM, byte counter, CRC, sticky flags and idle timer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            timer    <= '0;
            count    <= '0;
            crc      <= 8'h00;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else if (Start_i) begin
            state    <= ST_COLLECT;
            timer    <= '0;
            count    <= '0;
            crc      <= 8'h00;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else if (in_collect) begin
            if (accept) begin
                timer <= '0;
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + c_CntOne;
                    crc   <= crc8_step(crc, Data_i8b);
                end
            end else begin
                timer <= timer + c_TimerOne;
            end
            if (Finished_i) begin
                state <= ST_DONE;
            end else if (timeout_hit) begin
                state   <= ST_DONE;
                timeout <= 1'b1;
            end
        end else if (state != ST_DONE && state != ST_IDLE) begin
            state <= ST_IDLE;
        end
    end

    // Readout mask: only addresses below the current count return data.
    always_ff @(posedge clk) begin
        if (!rstn) rd_valid <= 1'b0;
        else       rd_valid <= ({1'b0, RdAddr_i} < count);
    end

    diag_readback_ram #(
        .g_Depth (g_Depth)
    ) u_ram (
        .clk     (clk),
        .wr_en   (store),
        .wr_addr (count[c_AddrW-1:0]),
        .wr_data (Data_i8b),
        .rd_addr (RdAddr_i),
        .rd_data (ram_q)
    );

    assign RdData_o8b = rd_valid ? ram_q : 8'h00;
    assign Ready_o    = in_collect;
    assign Complete_o = (state == ST_DONE);
    assign Count_o    = count;
    assign Crc_o8b    = crc;
    assign Overflow_o = overflow;
    assign Timeout_o  = timeout;

endmodule

// File: tb/tb_diag_readback_collector.sv
// Directed bench for diag_readback_collector (depth 16, timeout 10 cycles).
module tb_diag_readback_collector;

    localparam int c_Depth = 16;
    localparam int c_To    = 10;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       finished = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic [3:0] rd_addr = 4'd0;
    logic       ready;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic [7:0] crc;
    logic       overflow;
    logic       timeout;
    logic       complete;

    int n_cmp = 0;
    int n_bad = 0;

    diag_readback_collector #(
        .g_Depth         (c_Depth),
        .g_TimeoutCycles (c_To)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .Start_i    (start),
        .Finished_i (finished),
        .Data_i8b   (data),
        .Valid_i    (valid),
        .Ready_o    (ready),
        .RdAddr_i   (rd_addr),
        .RdData_o8b (rd_data),
        .Count_o    (count),
        .Crc_o8b    (crc),
        .Overflow_o (overflow),
        .Timeout_o  (timeout),
        .Complete_o (complete)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data  = b;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic pulse_finish();
        finished = 1'b1;
        tick();
        finished = 1'b0;
    endtask

    function automatic logic [7:0] ref_crc(input logic [7:0] c_in, input logic [7:0] b);
        logic [7:0] c;
        c = c_in ^ b;
        for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    function automatic logic [7:0] ovf_byte(input int i);
        return 8'((i * 7) + 3);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        string      digits;
        logic [7:0] exp_crc;
        int         n;

        digits = "123456789";

        // Reset values
        tick();
        tick();
        chk("rst_ready", ready, 0);
        chk("rst_complete", complete, 0);
        chk("rst_count", count, 0);
        chk("rst_crc", crc, 8'h00);
        chk("rst_ovf", overflow, 0);
        chk("rst_to", timeout, 0);
        chk("rst_rddata", rd_data, 8'h00);
        rstn = 1'b1;

        // Idle ignores bytes and finished
        send_byte(8'h77);
        pulse_finish();
        chk("idle_count", count, 0);
        chk("idle_complete", complete, 0);

        // Two bytes then finished
        pulse_start();
        chk("s1_ready", ready, 1);
        send_byte(8'h01);
        send_byte(8'h02);
        pulse_finish();
        chk("s1_count", count, 2);
        chk("s1_crc", crc, 8'h1B);
        chk("s1_complete", complete, 1);
        chk("s1_ready_done", ready, 0);
        chk("s1_ovf", overflow, 0);
        chk("s1_to", timeout, 0);
        rd_addr = 4'd0; tick(); chk("s1_rd0", rd_data, 8'h01);
        rd_addr = 4'd1; tick(); chk("s1_rd1", rd_data, 8'h02);
        rd_addr = 4'd2; tick(); chk("s1_rd2", rd_data, 8'h00);
        send_byte(8'h55);
        chk("done_ignore_count", count, 2);

        // "123456789" with random gaps
        pulse_start();
        chk("s2_count0", count, 0);
        chk("s2_crc0", crc, 8'h00);
        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_byte(digits[i]);
        end
        pulse_finish();
        chk("s2_crc", crc, 8'hF4);
        chk("s2_count", count, 9);
        rd_addr = 4'd8; tick(); chk("s2_rd8", rd_data, 8'h39);

        // Overflow: 18 bytes back to back
        pulse_start();
        exp_crc = 8'h00;
        for (int i = 0; i < 18; i++) begin
            chk("ovf_ready", ready, 1);
            if (i < c_Depth) exp_crc = ref_crc(exp_crc, ovf_byte(i));
            send_byte(ovf_byte(i));
            if (i == c_Depth - 1) begin
                chk("ovf_count16", count, 16);
                chk("ovf_flag_at16", overflow, 0);
            end
        end
        chk("ovf_ready_after", ready, 1);
        pulse_finish();
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_crc", crc, exp_crc);
        rd_addr = 4'd15; tick(); chk("ovf_rd15", rd_data, 8'h6C);

        // Timeout after silence
        pulse_start();
        chk("to_ovf_cleared", overflow, 0);
        send_byte(8'hA5);
        n = 0;
        while (!complete && n < 40) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 10);
        chk("to_flag", timeout, 1);
        chk("to_count", count, 1);

        // Finished in the timeout cycle wins
        pulse_start();
        chk("to2_flag_cleared", timeout, 0);
        send_byte(8'h5A);
        repeat (9) tick();
        chk("to2_pre", complete, 0);
        pulse_finish();
        chk("to2_complete", complete, 1);
        chk("to2_flag", timeout, 0);

        // Finished together with a byte: byte stored
        pulse_start();
        send_byte(8'h01);
        data = 8'h02; valid = 1'b1; finished = 1'b1;
        tick();
        valid = 1'b0; finished = 1'b0;
        chk("fin_byte_count", count, 2);
        chk("fin_byte_crc", crc, 8'h1B);
        chk("fin_byte_complete", complete, 1);

        // Start + byte + finished in COLLECT: restart wins
        pulse_start();
        send_byte(8'h33);
        chk("rs_pre_count", count, 1);
        start = 1'b1; valid = 1'b1; finished = 1'b1; data = 8'h44;
        tick();
        start = 1'b0; valid = 1'b0; finished = 1'b0;
        chk("rs_ready", ready, 1);
        chk("rs_complete", complete, 0);
        chk("rs_count", count, 0);
        chk("rs_crc", crc, 8'h00);

        // Reset mid-session
        for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i));
        chk("mr_count5", count, 5);
        rd_addr = 4'd0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mr_ready", ready, 0);
        chk("mr_complete", complete, 0);
        chk("mr_count", count, 0);
        chk("mr_crc", crc, 8'h00);
        chk("mr_ovf", overflow, 0);
        chk("mr_to", timeout, 0);
        chk("mr_rddata", rd_data, 8'h00);
        data = 8'hEE; valid = 1'b1;
        tick();
        finished = 1'b1;
        tick();
        finished = 1'b0;
        tick();
        valid = 1'b0;
        chk("mr_ign_count", count, 0);
        chk("mr_ign_ready", ready, 0);
        chk("mr_ign_complete", complete, 0);
        pulse_start();
        chk("mr_restart_ready", ready, 1);
        chk("mr_restart_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
